// File: rtl/aes_seq_if.sv
// Handshake/bus bundle between the AES job sequencer and its requester,
// core bank and display path.
interface aes_seq_if;
   logic         req_valid;
   logic         req_ready;
   logic         req_mode;
   logic [1:0]   req_key_type;
   logic         core_start;
   logic         core_mode;
   logic [1:0]   core_key_type;
   logic         core_done;
   logic [127:0] core_result;
   logic [7:0]   byte_out;
   logic         byte_valid;
   logic [3:0]   byte_index;
   logic         busy;
   logic         err;

   modport master (
      input  req_valid, req_mode, req_key_type,
      input  core_done, core_result,
      output req_ready, core_start, core_mode, core_key_type,
      output byte_out, byte_valid, byte_index, busy, err
   );

   modport slave (
      output req_valid, req_mode, req_key_type,
      output core_done, core_result,
      input  req_ready, core_start, core_mode, core_key_type,
      input  byte_out, byte_valid, byte_index, busy, err
   );
endinterface

// File: rtl/aes_job_sequencer.sv
// AES job sequencer: accept, core start, wait with timeout, result byte stream.
// Optional AES_SEQ_LOOP_EN: SHOW repeats forever and can accept a new job.
module aes_job_sequencer #(
   parameter int BYTES_SHOWN    = 4,
   parameter int HOLD_CYCLES    = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic      clk,
   input  logic      rst,
   aes_seq_if.master bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_SHOW
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic           w_ready;
   logic           w_accept;
   logic           w_bad_key;
   logic           w_done;
   logic           w_tout;
   logic           w_hold_end;
   logic           w_last;
   logic [TW-1:0]  r_tcnt;
   logic [HW-1:0]  r_hold;
   logic [3:0]     r_idx;
   logic [127:0]   r_res;
   logic [7:0]     r_byte;
   logic           r_mode;
   logic [1:0]     r_key;
   logic           r_err;
   logic [6:0]     w_sh_amt;
   logic [127:0]   w_shift;

   assign w_hold_end = (r_hold == HW'(HOLD_CYCLES - 1));
   assign w_last     = (r_idx == 4'(BYTES_SHOWN - 1));
   assign w_sh_amt   = {r_idx + 4'd1, 3'b000};
   assign w_shift    = r_res << w_sh_amt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_ready   = 1'b0;
      w_accept  = 1'b0;
      w_bad_key = 1'b0;
      w_done    = 1'b0;
      w_tout    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.req_valid) begin
               if (bus.req_key_type == 2'b11) begin
                  w_bad_key = 1'b1;
               end else begin
                  w_accept = 1'b1;
                  w_next   = S_START;
               end
            end
         end
         S_START: begin
            w_next = S_WAIT;
         end
         S_WAIT: begin
            // done is checked first so it wins over a same-edge timeout
            if (bus.core_done) begin
               w_done = 1'b1;
               w_next = S_SHOW;
            end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               w_tout = 1'b1;
               w_next = S_IDLE;
            end
         end
         S_SHOW: begin
`ifdef AES_SEQ_LOOP_EN
            w_ready = 1'b1;
            if (bus.req_valid) begin
               if (bus.req_key_type == 2'b11) begin
                  w_bad_key = 1'b1;
               end else begin
                  w_accept = 1'b1;
                  w_next   = S_START;
               end
            end
`else
            if (w_hold_end && w_last) begin
               w_next = S_IDLE;
            end
`endif
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt <= '0;
         r_hold <= '0;
         r_idx  <= '0;
         r_res  <= '0;
         r_byte <= '0;
         r_mode <= 1'b0;
         r_key  <= 2'b00;
         r_err  <= 1'b0;
      end else begin
         r_err <= w_bad_key | w_tout;
         if (w_accept) begin
            r_mode <= bus.req_mode;
            r_key  <= bus.req_key_type;
         end
         if (r_state == S_WAIT && !w_done && !w_tout) begin
            r_tcnt <= r_tcnt + TW'(1);
         end else begin
            r_tcnt <= '0;
         end
         if (w_done) begin
            r_res  <= bus.core_result;
            r_byte <= bus.core_result[127:120];
            r_idx  <= '0;
            r_hold <= '0;
         end else if (r_state == S_SHOW && w_next == S_SHOW) begin
            if (w_hold_end) begin
               r_hold <= '0;
               if (w_last) begin
                  r_idx  <= '0;
                  r_byte <= r_res[127:120];
               end else begin
                  r_idx  <= r_idx + 4'd1;
                  r_byte <= w_shift[127:120];
               end
            end else begin
               r_hold <= r_hold + HW'(1);
            end
         end else if (w_next != S_SHOW) begin
            r_idx  <= '0;
            r_hold <= '0;
            r_byte <= '0;
         end
      end
   end

   assign bus.req_ready     = w_ready;
   assign bus.core_start    = (r_state == S_START);
   assign bus.core_mode     = r_mode;
   assign bus.core_key_type = r_key;
   assign bus.byte_out      = r_byte;
   assign bus.byte_valid    = (r_state == S_SHOW);
   assign bus.byte_index    = r_idx;
   assign bus.busy          = (r_state != S_IDLE);
   assign bus.err           = r_err;
endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed table-driven bench for aes_job_sequencer.
// Also covers AES_SEQ_LOOP_EN builds when that macro is defined.
module tb_aes_job_sequencer;
   localparam int BS = 4;
   localparam int HC = 5;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_start = 0;
   int   n_bv = 0;

   aes_seq_if bus ();

   aes_job_sequencer #(
      .BYTES_SHOWN    (BS),
      .HOLD_CYCLES    (HC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      n_start += int'(bus.core_start);
      n_bv    += int'(bus.byte_valid);
   end

   typedef struct {
      logic         mode;
      logic [1:0]   key;
      int           dly;
      logic [127:0] res;
      logic         exp_err;
      logic [31:0]  exp_bytes;
   } vec_t;

   vec_t tv[5];
   vec_t v192;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, "_ready"}, bus.req_ready, 1);
      chk({nm, "_start"}, bus.core_start, 0);
      chk({nm, "_mode"}, bus.core_mode, 0);
      chk({nm, "_key"}, bus.core_key_type, 0);
      chk({nm, "_byte"}, bus.byte_out, 0);
      chk({nm, "_bv"}, bus.byte_valid, 0);
      chk({nm, "_idx"}, bus.byte_index, 0);
      chk({nm, "_busy"}, bus.busy, 0);
      chk({nm, "_err"}, bus.err, 0);
   endtask

   // call at a negedge; asserts rst between edges
   task automatic do_reset(input string nm);
      #2 rst = 1'b1;
      #1 chk_idle_outputs(nm);
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic accept(input logic m, input logic [1:0] k);
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_mode     = m;
      bus.req_key_type = k;
      @(negedge clk);
      bus.req_valid    = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int          s0;
      int          bv0;
      logic [31:0] eb;
      eb = v.exp_bytes;
      @(negedge clk);
      chk("idle_ready", bus.req_ready, 1);
      s0  = n_start;
      bv0 = n_bv;
      bus.req_valid    = 1'b1;
      bus.req_mode     = v.mode;
      bus.req_key_type = v.key;
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (v.key == 2'b11) begin
         chk("bad_err", bus.err, 1);
         chk("bad_ready", bus.req_ready, 1);
         chk("bad_busy", bus.busy, 0);
         @(negedge clk);
         chk("bad_err_end", bus.err, 0);
         chk("bad_nostart", n_start - s0, 0);
         return;
      end
      chk("start", bus.core_start, 1);
      chk("mode", bus.core_mode, v.mode);
      chk("key", bus.core_key_type, v.key);
      for (int c = 0; c < TO; c++) begin
         @(negedge clk);
         if (c == 0) chk("start_one", bus.core_start, 0);
         if (c == TO - 1) chk("no_early_err", bus.err, 0);
         if (c == v.dly) begin
            bus.core_done   = 1'b1;
            bus.core_result = v.res;
            break;
         end
      end
      @(negedge clk);
      bus.core_done   = 1'b0;
      bus.core_result = ~v.res;
      if (v.exp_err) begin
         chk("tout_err", bus.err, 1);
         chk("tout_busy", bus.busy, 0);
         chk("tout_nobyte", n_bv - bv0, 0);
         @(negedge clk);
         chk("tout_err_end", bus.err, 0);
         chk("tout_ready", bus.req_ready, 1);
         return;
      end
      for (int k = 0; k < BS; k++) begin
         for (int h = 0; h < HC; h++) begin
            if (k != 0 || h != 0) @(negedge clk);
            chk("bv", bus.byte_valid, 1);
            chk("byte", bus.byte_out, eb[31-8*k -: 8]);
            chk("idx", bus.byte_index, k);
         end
      end
      @(negedge clk);
      chk("one_start", n_start - s0, 1);
`ifdef AES_SEQ_LOOP_EN
      chk("wrap_bv", bus.byte_valid, 1);
      chk("wrap_idx", bus.byte_index, 0);
      chk("wrap_byte", bus.byte_out, eb[31:24]);
      do_reset("loop_rst");
`else
      chk("end_bv", bus.byte_valid, 0);
      chk("end_busy", bus.busy, 0);
      chk("end_ready", bus.req_ready, 1);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] eb;
      int          s0;
      int          bv0;

      tv[0] = '{1'b0, 2'b00, 9,  128'h3ad77bb40d7a3660a89ecaf32466ef97,
                1'b0, 32'h3ad77bb4};
      tv[1] = '{1'b0, 2'b11, 0,  128'h0, 1'b1, 32'h0};
      tv[2] = '{1'b1, 2'b10, -1, 128'h0, 1'b1, 32'h0};
      tv[3] = '{1'b1, 2'b01, 0,  128'h0123456789abcdeffedcba9876543210,
                1'b0, 32'h01234567};
      tv[4] = '{1'b0, 2'b10, TO - 1, 128'hffeeddccbbaa99887766554433221100,
                1'b0, 32'hffeeddcc};
      v192  = '{1'b1, 2'b01, 4,  128'h2b7e151628aed2a6abf7158809cf4f3c,
                1'b0, 32'h2b7e1516};

      bus.req_valid    = 1'b0;
      bus.req_mode     = 1'b0;
      bus.req_key_type = 2'b00;
      bus.core_done    = 1'b0;
      bus.core_result  = '0;

      #1 rst = 1'b1;
      #1 chk_idle_outputs("por");
      @(negedge clk) rst = 1'b0;

      foreach (tv[i]) run_vec(tv[i]);

      // wrong-state inputs: req_valid in START/WAIT/SHOW, core_done in SHOW
      eb = 32'h0f1e2d3c;
      s0 = n_start;
      accept(1'b1, 2'b01);
      bus.req_valid    = 1'b1;
      bus.req_mode     = 1'b0;
      bus.req_key_type = 2'b00;
      chk("ws_start", bus.core_start, 1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("ws_wait_ready", bus.req_ready, 0);
         chk("ws_wait_mode", bus.core_mode, 1);
         if (c == 3) begin
            bus.req_valid   = 1'b0;
            bus.core_done   = 1'b1;
            bus.core_result = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
         end
      end
      for (int k = 0; k < BS; k++) begin
         for (int h = 0; h < HC; h++) begin
            @(negedge clk);
            bus.core_done = 1'b0;
            bus.req_valid = 1'b0;
            chk("ws_byte", bus.byte_out, eb[31-8*k -: 8]);
            chk("ws_idx", bus.byte_index, k);
            chk("ws_mode", bus.core_mode, 1);
            chk("ws_key", bus.core_key_type, 2'b01);
            if (k == 1 && h == 2) begin
               bus.core_done   = 1'b1;
               bus.core_result = {4{32'haaaaaaaa}};
            end
`ifndef AES_SEQ_LOOP_EN
            if (k == 2 && h == 0) begin
               chk("ws_show_ready", bus.req_ready, 0);
               bus.req_valid = 1'b1;
            end
`endif
         end
      end
      @(negedge clk);
      chk("ws_one_start", n_start - s0, 1);
`ifdef AES_SEQ_LOOP_EN
      chk("ws_wrap_byte", bus.byte_out, eb[31:24]);
      do_reset("ws_rst");
`else
      chk("ws_end_busy", bus.busy, 0);
`endif

      // async reset while byte_index is 2
      accept(1'b0, 2'b00);
      @(negedge clk);
      bus.core_done   = 1'b1;
      bus.core_result = 128'h11223344556677889900aabbccddeeff;
      @(negedge clk);
      bus.core_done = 1'b0;
      repeat (2 * HC + 1) @(negedge clk);
      chk("mid_idx", bus.byte_index, 2);
      chk("mid_byte", bus.byte_out, 8'h33);
      s0 = n_start;
      #2 rst = 1'b1;
      #1 chk_idle_outputs("mid_rst");
      bv0 = n_bv;
      @(negedge clk) rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_no_bv", n_bv - bv0, 0);
      chk("mid_no_start", n_start - s0, 0);
      run_vec(v192);

`ifdef AES_SEQ_LOOP_EN
      // restart from SHOW, then an illegal key while showing
      accept(1'b0, 2'b00);
      @(negedge clk);
      bus.core_done   = 1'b1;
      bus.core_result = 128'h5566778899aabbccddeeff0011223344;
      @(negedge clk);
      bus.core_done = 1'b0;
      repeat (HC) @(negedge clk);
      chk("lp_idx1", bus.byte_index, 1);
      chk("lp_ready", bus.req_ready, 1);
      bus.req_valid    = 1'b1;
      bus.req_mode     = 1'b1;
      bus.req_key_type = 2'b10;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("lp_bv_drop", bus.byte_valid, 0);
      chk("lp_restart", bus.core_start, 1);
      chk("lp_key", bus.core_key_type, 2'b10);
      @(negedge clk);
      bus.core_done   = 1'b1;
      bus.core_result = 128'hc0ffee00000000000000000000000000;
      @(negedge clk);
      bus.core_done = 1'b0;
      chk("lp_new_byte", bus.byte_out, 8'hc0);
      bus.req_valid    = 1'b1;
      bus.req_mode     = 1'b0;
      bus.req_key_type = 2'b11;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("lp_bad_err", bus.err, 1);
      chk("lp_bad_bv", bus.byte_valid, 1);
      chk("lp_bad_key", bus.core_key_type, 2'b10);
      @(negedge clk);
      chk("lp_bad_err_end", bus.err, 0);
      do_reset("lp_rst");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
